// File: rtl/comp_mac_nch.sv
// comp_mac_nch: multi-lane pipelined multiply / multiply-accumulate with sticky per-lane overflow
module comp_mac_nch #(
    parameter int p_size     = 12,
    parameter int p_channels = 2,
    parameter int p_pipe     = 2,
    parameter int p_acc_w    = 28,
    parameter int p_signed   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    output logic                          i_ready,
    input  logic                          i_mode,
    input  logic                          i_clr,
    input  logic [p_channels*p_size-1:0]  i_param,
    input  logic [p_channels*p_size-1:0]  i_param_2,
    input  logic                          o_ready,
    output logic [p_channels*p_acc_w-1:0] o_param,
    output logic [p_channels-1:0]         o_ovf,
    output logic                          dv
);
    localparam int PW = 2 * p_size;
    localparam int DW = p_channels * PW + 3;

    logic                          w_stall;
    logic [DW-1:0]                 w_in;
    logic [DW-1:0]                 w_tail;
    logic [p_pipe-1:0][DW-1:0]     r_pipe;
    logic [p_channels*PW-1:0]      w_prod;
    logic [p_channels*p_acc_w-1:0] r_acc;
    logic [p_channels*p_acc_w-1:0] w_acc_nx;
    logic [p_channels*p_acc_w-1:0] w_out_nx;
    logic [p_channels-1:0]         w_ovf_nx;
    logic                          w_v;
    logic                          w_mode;
    logic                          w_clr;

    assign w_stall = dv & ~o_ready;
    assign i_ready = ~w_stall;
    assign w_in    = {ena, i_mode, i_clr, w_prod};
    assign w_tail  = r_pipe[p_pipe-1];
    assign w_v     = w_tail[DW-1];
    assign w_mode  = w_tail[DW-2];
    assign w_clr   = w_tail[DW-3];

    for (genvar k = 0; k < p_channels; k++) begin : g_lane
        logic [p_size-1:0]    w_a;
        logic [p_size-1:0]    w_b;
        logic signed [PW-1:0] w_ps;
        logic [PW-1:0]        w_pu;
        logic [PW-1:0]        w_p;
        logic [p_acc_w-1:0]   w_ext;
        logic [p_acc_w-1:0]   w_base;
        logic [p_acc_w:0]     w_sum;
        logic                 w_add_ovf;
        assign w_a  = i_param[k*p_size +: p_size];
        assign w_b  = i_param_2[k*p_size +: p_size];
        assign w_ps = $signed({{p_size{w_a[p_size-1]}}, w_a}) * $signed({{p_size{w_b[p_size-1]}}, w_b});
        assign w_pu = {{p_size{1'b0}}, w_a} * {{p_size{1'b0}}, w_b};
        assign w_prod[k*PW +: PW] = (p_signed != 0) ? w_ps : w_pu;
        // Product travels through the pipe; extension and accumulation happen at the output stage
        assign w_p    = w_tail[k*PW +: PW];
        assign w_ext  = (p_signed != 0) ? p_acc_w'($signed(w_p)) : p_acc_w'(w_p);
        assign w_base = w_clr ? '0 : r_acc[k*p_acc_w +: p_acc_w];
        assign w_sum  = {1'b0, w_base} + {1'b0, w_ext};
        assign w_add_ovf = (p_signed != 0)
            ? (w_base[p_acc_w-1] == w_ext[p_acc_w-1]) & (w_sum[p_acc_w-1] != w_base[p_acc_w-1])
            : w_sum[p_acc_w];
        assign w_ovf_nx[k] = (~w_clr & o_ovf[k]) | (w_mode & w_add_ovf);
        assign w_out_nx[k*p_acc_w +: p_acc_w] = w_mode ? w_sum[p_acc_w-1:0] : w_ext;
        assign w_acc_nx[k*p_acc_w +: p_acc_w] = w_mode ? w_sum[p_acc_w-1:0] : w_base;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe  <= '0;
            dv      <= 1'b0;
            o_param <= '0;
            o_ovf   <= '0;
            r_acc   <= '0;
        end else if (!w_stall) begin
            r_pipe[0] <= w_in;
            for (int j = 1; j < p_pipe; j++) r_pipe[j] <= r_pipe[j-1];
            dv <= w_v;
            if (w_v) begin
                o_param <= w_out_nx;
                o_ovf   <= w_ovf_nx;
                r_acc   <= w_acc_nx;
            end
        end
    end
endmodule

// File: tb/tb_comp_mac_nch.sv
// tb_comp_mac_nch: directed and random checks of comp_mac_nch (unsigned and signed instances)
module tb_comp_mac_nch;
    typedef struct {
        logic [55:0] pu;
        logic [55:0] ps;
        logic [1:0]  ou;
        logic [1:0]  os;
    } exp_t;

    localparam longint M = 64'd1 << 28;
    localparam longint H = 64'd1 << 27;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        i_mode;
    logic        i_clr;
    logic [23:0] i_param;
    logic [23:0] i_param_2;
    logic        o_ready;
    logic        i_ready;
    logic        dv;
    logic [55:0] o_param;
    logic [1:0]  o_ovf;
    logic        s_i_ready;
    logic        s_dv;
    logic [55:0] s_param;
    logic [1:0]  s_ovf;

    int     checks = 0;
    int     errors = 0;
    exp_t   q[$];
    longint acc_u[2];
    longint acc_s[2];
    bit     ovf_u[2];
    bit     ovf_s[2];
    bit     last_irdy;
    bit     last_acc;

    comp_mac_nch u_dut (
        .clk(clk), .rst(rst), .ena(ena), .i_ready(i_ready), .i_mode(i_mode), .i_clr(i_clr),
        .i_param(i_param), .i_param_2(i_param_2), .o_ready(o_ready),
        .o_param(o_param), .o_ovf(o_ovf), .dv(dv)
    );

    comp_mac_nch #(.p_signed(1)) u_sdut (
        .clk(clk), .rst(rst), .ena(ena), .i_ready(s_i_ready), .i_mode(i_mode), .i_clr(i_clr),
        .i_param(i_param), .i_param_2(i_param_2), .o_ready(o_ready),
        .o_param(s_param), .o_ovf(s_ovf), .dv(s_dv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [11:0] v);
        return v[11] ? longint'(v) - 4096 : longint'(v);
    endfunction

    function automatic longint wrap_s(input longint v);
        longint x = v & (M - 1);
        return (x >= H) ? x - M : x;
    endfunction

    task automatic model_clear();
        q.delete();
        for (int k = 0; k < 2; k++) begin
            acc_u[k] = 0; acc_s[k] = 0; ovf_u[k] = 0; ovf_s[k] = 0;
        end
    endtask

    task automatic push(input bit m, input bit c, input logic [23:0] pa, input logic [23:0] pb);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            logic [11:0] a = pa[k*12 +: 12];
            logic [11:0] b = pb[k*12 +: 12];
            longint pu = longint'(a) * longint'(b);
            longint ps = sx(a) * sx(b);
            longint ru, rs, su, ss;
            if (c) begin ovf_u[k] = 0; ovf_s[k] = 0; end
            if (m) begin
                su = (c ? 0 : acc_u[k]) + pu;
                if (su >= M) ovf_u[k] = 1;
                acc_u[k] = su % M;
                ru = acc_u[k];
                ss = (c ? 0 : acc_s[k]) + ps;
                if (ss >= H || ss < -H) ovf_s[k] = 1;
                acc_s[k] = wrap_s(ss);
                rs = acc_s[k];
            end else begin
                if (c) begin acc_u[k] = 0; acc_s[k] = 0; end
                ru = pu;
                rs = ps;
            end
            e.pu[k*28 +: 28] = ru[27:0];
            e.ps[k*28 +: 28] = rs[27:0];
            e.ou[k] = ovf_u[k];
            e.os[k] = ovf_s[k];
        end
        q.push_back(e);
    endtask

    task automatic take();
        exp_t e;
        chk("output_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("u_param", o_param, e.pu);
            chk("u_ovf", o_ovf, e.ou);
            chk("s_dv", s_dv, 1);
            chk("s_param", s_param, e.ps);
            chk("s_ovf", s_ovf, e.os);
        end
    endtask

    task automatic step(input bit e, input bit m, input bit c, input logic [11:0] a0, input logic [11:0] b0,
                        input logic [11:0] a1, input logic [11:0] b1, input bit rdy);
        ena = e; i_mode = m; i_clr = c; o_ready = rdy;
        i_param = {a1, a0}; i_param_2 = {b1, b0};
        @(negedge clk);
        chk("i_ready_rule", i_ready, !(dv && !o_ready));
        chk("s_i_ready_rule", s_i_ready, !(s_dv && !o_ready));
        last_irdy = i_ready;
        last_acc = ena && i_ready;
        if (dv && o_ready) take();
        if (last_acc) push(i_mode, i_clr, i_param, i_param_2);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            idle();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        chk("rst_dv", dv, 0);
        chk("rst_param", o_param, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_s_dv", s_dv, 0);
        chk("rst_s_param", s_param, 0);
        chk("rst_s_ovf", s_ovf, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1;
        chk("rst_i_ready", i_ready, 1);
    endtask

    initial begin
        rst = 1; ena = 0; i_mode = 0; i_clr = 0; i_param = '0; i_param_2 = '0; o_ready = 1;
        #2;
        do_reset();

        // mode 0 products and latency
        step(1, 0, 0, 12'd4095, 12'd4095, 12'd3, 12'd7, 1);
        chk("t1_dv_e0", dv, 0);
        idle();
        chk("t1_dv_e1", dv, 0);
        idle();
        chk("t1_dv_e2", dv, 1);
        chk("t1_ch0", o_param[27:0], 28'd16769025);
        chk("t1_ch1", o_param[55:28], 28'd21);
        chk("t1_ovf", o_ovf, 0);
        drain();

        // signed products
        step(1, 0, 0, 12'hFFF, 12'hFFF, 12'h800, 12'h7FF, 1);
        idle();
        idle();
        chk("t6_ch0", s_param[27:0], 28'd1);
        chk("t6_ch1", s_param[55:28], 28'hFC00800);
        drain();

        // accumulate with clear
        step(1, 1, 1, 12'd100, 12'd100, 0, 0, 1);
        step(1, 1, 0, 12'd100, 12'd100, 0, 0, 1);
        step(1, 1, 0, 12'd100, 12'd100, 0, 0, 1);
        chk("t2_r1", o_param[27:0], 28'd10000);
        step(1, 1, 1, 12'd5, 12'd5, 0, 0, 1);
        chk("t2_r2", o_param[27:0], 28'd20000);
        idle();
        chk("t2_r3", o_param[27:0], 28'd30000);
        idle();
        chk("t2_r4", o_param[27:0], 28'd25);
        drain();

        // accumulator wrap and sticky overflow
        for (int i = 0; i < 17; i++) step(1, 1, i == 0, 12'd4095, 12'd4095, 0, 0, 1);
        idle();
        chk("t3_r16", o_param[27:0], 28'd268304400);
        chk("t3_ovf16", o_ovf[0], 0);
        idle();
        chk("t3_r17", o_param[27:0], 28'd16637969);
        chk("t3_ovf17", o_ovf[0], 1);
        step(1, 0, 0, 12'd1, 12'd1, 0, 0, 1);
        idle();
        idle();
        chk("t3_sticky_ovf", o_ovf[0], 1);
        chk("t3_sticky_param", o_param[27:0], 28'd1);
        drain();

        // reset with samples in flight
        step(1, 1, 0, 12'd1, 12'd1, 0, 0, 1);
        step(1, 1, 0, 12'd1, 12'd1, 0, 0, 1);
        step(1, 1, 0, 12'd1, 12'd1, 0, 0, 1);
        chk("t5_pre_dv", dv, 1);
        chk("t5_pre_ovf", o_ovf[0], 1);
        do_reset();
        step(1, 1, 0, 12'd2, 12'd3, 0, 0, 1);
        idle();
        idle();
        chk("t5_after", o_param[27:0], 28'd6);
        chk("t5_after_ovf", o_ovf, 0);
        drain();

        // streaming with a 3-cycle consumer stall
        begin
            int i = 1;
            int cyc = 0;
            while (i <= 8 && cyc < 40) begin
                bit rdy = !(cyc >= 4 && cyc < 7);
                step(1, 0, 0, 12'(i), 12'd1, 0, 0, rdy);
                if (!rdy) chk("t4_stall_irdy", last_irdy, 0);
                if (last_acc) i++;
                cyc++;
            end
            chk("t4_all_accepted", i, 9);
        end
        drain();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [11:0] a0 = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
            logic [11:0] b0 = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
            logic [11:0] a1 = ($urandom_range(0, 3) == 0) ? 12'h800 : 12'($urandom_range(0, 4095));
            logic [11:0] b1 = 12'($urandom_range(0, 4095));
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                 a0, b0, a1, b1, $urandom_range(0, 3) != 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
